// File: rtl/opti_fixed_pkg.sv
// Shared Q2.13 constants, divider state encoding and a magnitude helper
// for the opti_divider slice.
package opti_fixed_pkg;

   localparam int Q_WIDTH   = 16;
   localparam int Q_FRAC    = 13;
   localparam int MAG_WIDTH = Q_WIDTH + 1;

   localparam logic [Q_WIDTH-1:0] Q_MAX = 16'h7FFF;
   localparam logic [Q_WIDTH-1:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      CALC = 2'd2,
      POST = 2'd3
   } state_t;

   // 17-bit magnitude so that the most negative code (0x8000) maps to 32768.
   function automatic logic [MAG_WIDTH-1:0] mag_of(input logic [Q_WIDTH-1:0] v);
      logic [MAG_WIDTH-1:0] ext_s;
      ext_s = {v[Q_WIDTH-1], v};
      if (v[Q_WIDTH-1]) begin
         mag_of = 17'd0 - ext_s;
      end else begin
         mag_of = ext_s;
      end
   endfunction

endpackage

// File: rtl/opti_divider_if.sv
// Start/operand/result bundle of the Q2.13 divider; master drives the
// request, slave is the divider.
interface opti_divider_if;
   import opti_fixed_pkg::*;

   logic               en;
   logic [Q_WIDTH-1:0] a;
   logic [Q_WIDTH-1:0] b;
   logic [Q_WIDTH-1:0] q;
   logic               valid;
   logic               busy;
   logic               sat;
   logic               dz;

   modport master (
      output en, a, b,
      input  q, valid, busy, sat, dz
   );

   modport slave (
      input  en, a, b,
      output q, valid, busy, sat, dz
   );

endinterface

// File: rtl/opti_sat_round.sv
// Result shaping for the divider: guard-bit rounding (only when
// OPTI_DIV_ROUND_EN is defined, truncation otherwise), sign and saturation.
module opti_sat_round
   import opti_fixed_pkg::*;
(
   input  logic [Q_WIDTH-1:0] quo,
   input  logic               neg,
   input  logic               zdiv,
   input  logic               ovf,
   input  logic               a_zero,
   output logic [Q_WIDTH-1:0] q,
   output logic               sat
);

   logic [Q_WIDTH-1:0] mag_s;

`ifdef OPTI_DIV_ROUND_EN
   // Round half away from zero on the magnitude; may reach 0x8000.
   always_comb begin
      mag_s = {1'b0, quo[Q_WIDTH-1:1]} + {15'd0, quo[0]};
   end
`else
   logic unused_guard_s;
   assign unused_guard_s = quo[0];

   // Truncate toward zero: the guard bit is simply dropped.
   always_comb begin
      mag_s = {1'b0, quo[Q_WIDTH-1:1]};
   end
`endif

   // Special cases first, then sign application with clamping.
   always_comb begin
      q   = 16'h0000;
      sat = 1'b0;
      if (zdiv) begin
         if (a_zero) begin
            q   = 16'h0000;
            sat = 1'b0;
         end else if (neg) begin
            q   = Q_MIN;
            sat = 1'b1;
         end else begin
            q   = Q_MAX;
            sat = 1'b1;
         end
      end else if (ovf) begin
         q   = neg ? Q_MIN : Q_MAX;
         sat = 1'b1;
      end else if (mag_s == 16'h0000) begin
         q   = 16'h0000;
         sat = 1'b0;
      end else if (neg) begin
         if (mag_s > 16'h8000) begin
            q   = Q_MIN;
            sat = 1'b1;
         end else begin
            q   = 16'h0000 - mag_s;
            sat = 1'b0;
         end
      end else begin
         if (mag_s > Q_MAX) begin
            q   = Q_MAX;
            sat = 1'b1;
         end else begin
            q   = mag_s;
            sat = 1'b0;
         end
      end
   end

endmodule

// File: rtl/opti_divider.sv
// Fixed-latency Q2.13 signed divider: restoring division, 16 quotient bits,
// result shaping in opti_sat_round (build option OPTI_DIV_ROUND_EN).
module opti_divider
   import opti_fixed_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   opti_divider_if.slave bus
);

   localparam int GUARD_SHIFT = Q_FRAC + 1;

   state_t               state_r;
   state_t               state_nxt_s;

   logic [Q_WIDTH-1:0]   a_r;
   logic [Q_WIDTH-1:0]   b_r;
   logic [MAG_WIDTH-1:0] mag_a_s;
   logic [MAG_WIDTH-1:0] mag_b_s;

   logic [MAG_WIDTH-1:0] dvs_r;
   logic [MAG_WIDTH-1:0] rem_r;
   logic [Q_WIDTH-1:0]   dvd_r;
   logic [Q_WIDTH-2:0]   quo_r;
   logic [3:0]           cnt_r;
   logic                 neg_r;
   logic                 zdiv_r;
   logic                 ovf_r;
   logic                 a_zero_r;

   logic [MAG_WIDTH:0]   trial_s;
   logic                 qbit_s;
   logic [Q_WIDTH-1:0]   quo_nxt_s;

   logic                 capture_s;
   logic                 prep_s;
   logic                 step_s;
   logic                 done_s;

   logic [Q_WIDTH-1:0]   res_q_s;
   logic                 res_sat_s;

   logic [Q_WIDTH-1:0]   q_r;
   logic                 valid_r;
   logic                 busy_r;
   logic                 sat_r;
   logic                 dz_r;

   assign mag_a_s   = mag_of(a_r);
   assign mag_b_s   = mag_of(b_r);
   assign trial_s   = {rem_r, dvd_r[Q_WIDTH-1]};
   assign qbit_s    = (trial_s >= {1'b0, dvs_r});
   assign quo_nxt_s = {quo_r, qbit_s};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; POST is the valid cycle and accepts en like IDLE so that
   // a held en streams results exactly 18 cycles apart.
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE: begin
            if (bus.en) begin
               state_nxt_s = PREP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PREP: state_nxt_s = CALC;
         CALC: begin
            if (cnt_r == 4'd15) begin
               state_nxt_s = POST;
            end else begin
               state_nxt_s = CALC;
            end
         end
         POST: begin
            if (bus.en) begin
               state_nxt_s = PREP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath strobes decoded from the state.
   always_comb begin
      capture_s = 1'b0;
      prep_s    = 1'b0;
      step_s    = 1'b0;
      done_s    = 1'b0;
      case (state_r)
         IDLE: capture_s = bus.en;
         PREP: prep_s    = 1'b1;
         CALC: begin
            step_s = 1'b1;
            done_s = (cnt_r == 4'd15);
         end
         POST: capture_s = bus.en;
         default: capture_s = 1'b0;
      endcase
   end

   // Operand capture, PREP classification and one restoring step per CALC
   // cycle. The initial remainder |a|>>2 is below |b| whenever no overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= 16'h0000;
         b_r      <= 16'h0000;
         dvs_r    <= 17'd0;
         rem_r    <= 17'd0;
         dvd_r    <= 16'h0000;
         quo_r    <= 15'd0;
         cnt_r    <= 4'd0;
         neg_r    <= 1'b0;
         zdiv_r   <= 1'b0;
         ovf_r    <= 1'b0;
         a_zero_r <= 1'b0;
      end else begin
         if (capture_s) begin
            a_r <= bus.a;
            b_r <= bus.b;
         end
         if (prep_s) begin
            dvs_r    <= mag_b_s;
            rem_r    <= {2'b00, mag_a_s[MAG_WIDTH-1:2]};
            dvd_r    <= {mag_a_s[1:0], {GUARD_SHIFT{1'b0}}};
            quo_r    <= 15'd0;
            cnt_r    <= 4'd0;
            neg_r    <= a_r[Q_WIDTH-1] ^ b_r[Q_WIDTH-1];
            zdiv_r   <= (b_r == 16'h0000);
            ovf_r    <= ({2'b00, mag_a_s} >= {mag_b_s, 2'b00});
            a_zero_r <= (a_r == 16'h0000);
         end
         if (step_s) begin
            if (qbit_s) begin
               rem_r <= MAG_WIDTH'(trial_s - {1'b0, dvs_r});
            end else begin
               rem_r <= MAG_WIDTH'(trial_s);
            end
            dvd_r <= {dvd_r[Q_WIDTH-2:0], 1'b0};
            quo_r <= quo_nxt_s[Q_WIDTH-2:0];
            cnt_r <= cnt_r + 4'd1;
         end
      end
   end

   opti_sat_round u_sat_round (
      .quo    (quo_nxt_s),
      .neg    (neg_r),
      .zdiv   (zdiv_r),
      .ovf    (ovf_r),
      .a_zero (a_zero_r),
      .q      (res_q_s),
      .sat    (res_sat_s)
   );

   // Registered results; the last quotient bit feeds the shaper directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r     <= 16'h0000;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         sat_r   <= 1'b0;
         dz_r    <= 1'b0;
      end else begin
         valid_r <= done_s;
         if (capture_s) begin
            busy_r <= 1'b1;
         end else if (done_s) begin
            busy_r <= 1'b0;
         end
         if (done_s) begin
            q_r   <= res_q_s;
            sat_r <= res_sat_s;
            dz_r  <= zdiv_r;
         end
      end
   end

   assign bus.q     = q_r;
   assign bus.valid = valid_r;
   assign bus.busy  = busy_r;
   assign bus.sat   = sat_r;
   assign bus.dz    = dz_r;

endmodule

// File: tb/tb_opti_divider.sv
// Randomized self-checking bench for opti_divider against an arithmetic
// reference model (honours OPTI_DIV_ROUND_EN the same way as the design).
module tb_opti_divider;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [15:0] prev_q;
   logic        prev_sat;
   logic        prev_dz;

   opti_divider_if bus ();

   opti_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: a/b scaled by 2^13 computed directly, then clamped.
   function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                 output logic [15:0] q, output logic sat, output logic dz);
      longint sa, sb, ma, mb, m, r;
      sa  = longint'($signed(av));
      sb  = longint'($signed(bv));
      ma  = (sa < 64'sd0) ? -sa : sa;
      mb  = (sb < 64'sd0) ? -sb : sb;
      dz  = (bv == 16'h0000);
      sat = 1'b0;
      q   = 16'h0000;
      if (sb == 64'sd0) begin
         if (sa > 64'sd0) begin
            q = 16'h7FFF; sat = 1'b1;
         end else if (sa < 64'sd0) begin
            q = 16'h8000; sat = 1'b1;
         end else begin
            q = 16'h0000;
         end
      end else if (ma >= 64'sd4 * mb) begin
         sat = 1'b1;
         q   = ((sa < 64'sd0) != (sb < 64'sd0)) ? 16'h8000 : 16'h7FFF;
      end else begin
`ifdef OPTI_DIV_ROUND_EN
         m = (ma * 64'sd16384 + mb) / (64'sd2 * mb);
`else
         m = (ma * 64'sd8192) / mb;
`endif
         r = ((sa < 64'sd0) != (sb < 64'sd0)) ? -m : m;
         if (r > 64'sd32767) begin
            q = 16'h7FFF; sat = 1'b1;
         end else if (r < -64'sd32768) begin
            q = 16'h8000; sat = 1'b1;
         end else begin
            q = 16'(r);
         end
      end
   endfunction

   // One division; optional en/operand noise while busy must be ignored.
   task automatic do_div(input logic [15:0] av, input logic [15:0] bv, input bit noisy);
      logic [15:0] eq;
      logic        es;
      logic        ed;
      int          first_valid;
      int          busy_bad;
      int          hold_bad;
      model(av, bv, eq, es, ed);
      @(negedge clk);
      bus.en = 1'b1; bus.a = av; bus.b = bv;
      @(posedge clk);
      first_valid = 0; busy_bad = 0; hold_bad = 0;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         @(negedge clk);
         if (bus.busy !== (cyc <= 17)) busy_bad++;
         if (bus.valid === 1'b1 && first_valid == 0) first_valid = cyc;
         if (cyc < 18 && (bus.q !== prev_q || bus.sat !== prev_sat || bus.dz !== prev_dz)) hold_bad++;
         if (cyc < 18 && noisy) begin
            bus.en = 1'($urandom_range(0, 1));
            bus.a  = 16'($urandom);
            bus.b  = 16'($urandom);
         end else begin
            bus.en = 1'b0;
         end
      end
      check_val($sformatf("latency a=%h b=%h", av, bv), 32'(first_valid), 32'd18);
      check_val($sformatf("busy a=%h b=%h", av, bv), 32'(busy_bad), 32'd0);
      check_val($sformatf("hold a=%h b=%h", av, bv), 32'(hold_bad), 32'd0);
      check_val($sformatf("q a=%h b=%h", av, bv), 32'(bus.q), 32'(eq));
      check_val($sformatf("sat a=%h b=%h", av, bv), 32'(bus.sat), 32'(es));
      check_val($sformatf("dz a=%h b=%h", av, bv), 32'(bus.dz), 32'(ed));
      prev_q = eq; prev_sat = es; prev_dz = ed;
      @(negedge clk);
      check_val("valid_pulse", 32'(bus.valid), 32'd0);
   endtask

   // en held high across two operations: results exactly 18 cycles apart.
   task automatic b2b(input logic [15:0] a1, input logic [15:0] b1,
                      input logic [15:0] a2, input logic [15:0] b2);
      logic [15:0] q1, q2;
      logic        s1, s2, d1, d2;
      logic [15:0] got1, got2;
      int          vcnt;
      logic        busy19;
      model(a1, b1, q1, s1, d1);
      model(a2, b2, q2, s2, d2);
      got1 = 16'h0000; got2 = 16'h0000; vcnt = 0; busy19 = 1'b0;
      @(negedge clk);
      bus.en = 1'b1; bus.a = a1; bus.b = b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (bus.valid === 1'b1) begin
            vcnt++;
            if (cyc == 18) got1 = bus.q;
            if (cyc == 36) got2 = bus.q;
         end
         if (cyc == 19) busy19 = bus.busy;
         if (cyc == 1) begin
            bus.a = a2; bus.b = b2;
         end
         if (cyc == 36) bus.en = 1'b0;
      end
      check_val("b2b_pulses", 32'(vcnt), 32'd2);
      check_val("b2b_q1", 32'(got1), 32'(q1));
      check_val("b2b_q2", 32'(got2), 32'(q2));
      check_val("b2b_busy_restart", 32'(busy19), 32'd1);
      prev_q = q2; prev_sat = s2; prev_dz = d2;
   endtask

   // Reset pulled in cycle 9 of an operation.
   task automatic reset_mid(input logic [15:0] av, input logic [15:0] bv);
      int vcnt;
      @(negedge clk);
      bus.en = 1'b1; bus.a = av; bus.b = bv;
      @(posedge clk);
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(negedge clk);
         bus.en = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_outputs", 32'({bus.q, bus.valid, bus.busy, bus.sat, bus.dz}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(negedge clk);
         if (bus.valid === 1'b1) vcnt++;
      end
      check_val("rst_no_valid", 32'(vcnt), 32'd0);
      check_val("rst_after_outputs", 32'({bus.q, bus.valid, bus.busy, bus.sat, bus.dz}), 32'd0);
      prev_q = 16'h0000; prev_sat = 1'b0; prev_dz = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] av;
      logic [15:0] bv;
      n_tests = 0; n_fail = 0;
      prev_q = 16'h0000; prev_sat = 1'b0; prev_dz = 1'b0;
      rst_n = 1'b0; bus.en = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000;
      @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      check_val("reset_q", 32'(bus.q), 32'd0);
      check_val("reset_valid", 32'(bus.valid), 32'd0);
      check_val("reset_busy", 32'(bus.busy), 32'd0);
      check_val("reset_sat", 32'(bus.sat), 32'd0);
      check_val("reset_dz", 32'(bus.dz), 32'd0);
      bus.en = 1'b0;
      rst_n = 1'b1;

      do_div(16'h2000, 16'h4000, 1'b0);
      do_div(16'hE000, 16'h6000, 1'b0);
      do_div(16'h7FFF, 16'h1000, 1'b1);
      do_div(16'h8000, 16'h8000, 1'b0);
      do_div(16'h0000, 16'h0000, 1'b0);
      do_div(16'hC000, 16'h0000, 1'b0);
      do_div(16'hFFFF, 16'h7FFF, 1'b0);
      do_div(16'h8000, 16'h2000, 1'b0);
      do_div(16'h7FFF, 16'h2000, 1'b0);
      do_div(16'h2000, 16'h0000, 1'b0);
      reset_mid(16'h1234, 16'h0567);
      do_div(16'h2000, 16'h4000, 1'b0);
      b2b(16'h2000, 16'h4000, 16'hE000, 16'h6000);

      for (int i = 0; i < 40; i++) begin
         av = 16'($urandom);
         bv = 16'($urandom);
         case ($urandom_range(0, 5))
            0: bv = 16'h0000;
            1: av = {{3{av[15]}}, av[15:3]};
            2: av = {{5{av[15]}}, av[15:5]};
            3: av = 16'h8000;
            default: av = av;
         endcase
         do_div(av, bv, (i % 2) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
